// File: rtl/sat_sub_accum_8bit.sv
// Signed saturating subtract-accumulator: folds a frame of N_OPS operands into
// acc = sat(acc - x) and hands the result out over a valid/ready stream.
module sat_sub_accum_8bit #(
    parameter int N_OPS = 4,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ACC_W-1:0] init_val,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             ovf_sticky,
    output logic             uvf_sticky,
    output logic             busy,
    output logic [7:0]       op_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam logic [7:0]       LAST_CNT = 8'(N_OPS - 1);
    localparam logic [ACC_W-1:0] SAT_POS  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_NEG  = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           state_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [7:0]       op_cnt_reg;
    logic             ovf_reg;
    logic             uvf_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             busy_reg;

    logic [ACC_W:0]   diff;
    logic             step_ovf;
    logic             step_uvf;
    logic [ACC_W-1:0] step_val;

    // One extra bit of headroom: the top two bits disagree exactly when the
    // true difference left the signed 8-bit range, and bit 8 gives the side.
    always_comb begin
        diff     = {acc_reg[ACC_W-1], acc_reg} - {in_data[ACC_W-1], in_data};
        step_ovf = (diff[ACC_W:ACC_W-1] == 2'b01);
        step_uvf = (diff[ACC_W:ACC_W-1] == 2'b10);
        step_val = diff[ACC_W-1:0];
        if (step_ovf) begin
            step_val = SAT_POS;
        end else if (step_uvf) begin
            step_val = SAT_NEG;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            op_cnt_reg    <= '0;
            ovf_reg       <= 1'b0;
            uvf_reg       <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg    <= ACCUM;
                        acc_reg      <= init_val;
                        op_cnt_reg   <= '0;
                        ovf_reg      <= 1'b0;
                        uvf_reg      <= 1'b0;
                        in_ready_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                    end
                end
                ACCUM: begin
                    // in_ready is always high here, so in_valid alone is the handshake
                    if (in_valid) begin
                        acc_reg    <= step_val;
                        op_cnt_reg <= op_cnt_reg + 8'd1;
                        ovf_reg    <= ovf_reg | step_ovf;
                        uvf_reg    <= uvf_reg | step_uvf;
                        if (op_cnt_reg == LAST_CNT) begin
                            state_reg     <= DONE;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b0;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_reg;
    assign out_valid  = out_valid_reg;
    assign out_data   = acc_reg;
    assign ovf_sticky = ovf_reg;
    assign uvf_sticky = uvf_reg;
    assign busy       = busy_reg;
    assign op_cnt     = op_cnt_reg;

endmodule

// File: tb/tb_sat_sub_accum_8bit.sv
// Bench for sat_sub_accum_8bit: directed and random frames against an
// integer-arithmetic model of saturating subtraction.
module tb_sat_sub_accum_8bit;

    localparam int NOPS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] init_val = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       ovf_sticky;
    logic       uvf_sticky;
    logic       busy;
    logic [7:0] op_cnt;

    int checks = 0;
    int failures = 0;

    int m_acc;
    bit m_ovf;
    bit m_uvf;

    sat_sub_accum_8bit #(.N_OPS(NOPS), .ACC_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .init_val   (init_val),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .ovf_sticky (ovf_sticky),
        .uvf_sticky (uvf_sticky),
        .busy       (busy),
        .op_cnt     (op_cnt)
    );

    always #5 clk = ~clk;

    // Reference: true integer difference, clamped to the signed byte range.
    function automatic void model_step(input int x);
        int r;
        r = m_acc - x;
        if (r > 127) begin
            m_acc = 127;
            m_ovf = 1'b1;
        end else if (r < -128) begin
            m_acc = -128;
            m_uvf = 1'b1;
        end else begin
            m_acc = r;
        end
    endfunction

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, busy, ovf_sticky, uvf_sticky, out_data, op_cnt} !== 21'd0) begin
            failures++;
            $display("FAIL reset_hold: outputs=%h required 0", {out_valid, in_ready, busy, ovf_sticky, uvf_sticky, out_data, op_cnt});
        end
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h55;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || op_cnt !== 8'd0 || out_data !== 8'd0) begin
            failures++;
            $display("FAIL idle_ignores_valid: busy=%b in_ready=%b op_cnt=%0d out_data=%h required 0 0 0 00",
                     busy, in_ready, op_cnt, out_data);
        end
        $display("reset: outputs zero, idle ignores in_valid");
    endtask

    // Runs one frame starting from a negedge in IDLE; leaves start high if chaining.
    task automatic run_frame(input string name, input int init, input int ops[NOPS], input int gap,
                             input int stall, input bit poke_start, input bit chain, input int next_init);
        logic [7:0] held;
        init_val = 8'(init);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_acc = init;
        m_ovf = 1'b0;
        m_uvf = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || op_cnt !== 8'd0 || out_data !== 8'(init)
            || ovf_sticky !== 1'b0 || uvf_sticky !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_start: busy=%b rdy=%b cnt=%0d acc=%h ovf=%b uvf=%b ov=%b required 1 1 0 %h 0 0 0",
                     name, busy, in_ready, op_cnt, out_data, ovf_sticky, uvf_sticky, out_valid, 8'(init));
        end
        for (int i = 0; i < NOPS; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_data = 8'($urandom_range(0, 255));
                start = poke_start;
                init_val = 8'($urandom_range(0, 255));
                @(negedge clk);
                start = 1'b0;
                checks++;
                if (op_cnt !== 8'(i) || out_data !== 8'(m_acc) || in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_stall%0d: cnt=%0d acc=%h rdy=%b required %0d %h 1",
                             name, i, op_cnt, out_data, in_ready, i, 8'(m_acc));
                end
            end
            in_valid = 1'b1;
            in_data = 8'(ops[i]);
            @(negedge clk);
            in_valid = 1'b0;
            model_step(ops[i]);
            checks++;
            if (out_data !== 8'(m_acc) || op_cnt !== 8'(i + 1) || ovf_sticky !== m_ovf || uvf_sticky !== m_uvf
                || out_valid !== (i == NOPS - 1) || in_ready !== (i != NOPS - 1)) begin
                failures++;
                $display("FAIL %s_beat%0d: acc=%h cnt=%0d ovf=%b uvf=%b ov=%b rdy=%b required %h %0d %b %b %b %b",
                         name, i, out_data, op_cnt, ovf_sticky, uvf_sticky, out_valid, in_ready,
                         8'(m_acc), i + 1, m_ovf, m_uvf, (i == NOPS - 1), (i != NOPS - 1));
            end
        end
        held = 8'(m_acc);
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            start = poke_start;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_data !== held || busy !== 1'b1 || in_ready !== 1'b0 || ovf_sticky !== m_ovf) begin
                failures++;
                $display("FAIL %s_out_stall%0d: ov=%b data=%h busy=%b rdy=%b ovf=%b required 1 %h 1 0 %b",
                         name, s, out_valid, out_data, busy, in_ready, ovf_sticky, held, m_ovf);
            end
        end
        out_ready = 1'b1;
        start = chain | poke_start;
        init_val = chain ? 8'(next_init) : 8'($urandom_range(0, 255));
        @(negedge clk);
        out_ready = 1'b0;
        if (!chain) start = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_data !== held
            || ovf_sticky !== m_ovf || uvf_sticky !== m_uvf || op_cnt !== 8'(NOPS)) begin
            failures++;
            $display("FAIL %s_handshake: ov=%b busy=%b rdy=%b data=%h ovf=%b uvf=%b cnt=%0d required 0 0 0 %h %b %b %0d",
                     name, out_valid, busy, in_ready, out_data, ovf_sticky, uvf_sticky, op_cnt,
                     held, m_ovf, m_uvf, NOPS);
        end
        $display("frame %s: init=%0d result=%h ovf=%b uvf=%b", name, init, out_data, ovf_sticky, uvf_sticky);
    endtask

    task automatic test_directed();
        run_frame("basic", 10, '{3, 4, -5, 1}, 0, 0, 1'b0, 1'b0, 0);
        run_frame("ovf", 100, '{-50, -1, 27, 0}, 0, 1, 1'b0, 1'b0, 0);
        run_frame("uvf", -100, '{50, 0, 0, -1}, 1, 0, 1'b0, 1'b0, 0);
        run_frame("minus128", 0, '{-128, 0, 0, 0}, 2, 5, 1'b1, 1'b0, 0);
    endtask

    task automatic test_reset_mid_frame();
        init_val = 8'd20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            in_valid = 1'b1;
            in_data = 8'd7;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, busy, ovf_sticky, uvf_sticky, out_data, op_cnt} !== 21'd0) begin
            failures++;
            $display("FAIL async_reset: outputs=%h required 0", {out_valid, in_ready, busy, ovf_sticky, uvf_sticky, out_data, op_cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_idle: busy=%b ov=%b required 0 0", busy, out_valid);
        end
        $display("reset mid-frame: frame discarded");
        run_frame("post_reset", 5, '{1, 1, 1, 1}, 0, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_first", 100, '{-50, -1, 27, 0}, 0, 0, 1'b0, 1'b1, 3);
        run_frame("b2b_second", 3, '{1, 1, 0, -1}, 0, 0, 1'b0, 1'b0, 0);
    endtask

    function automatic int pick_val();
        int sel;
        sel = int'($urandom_range(0, 7));
        case (sel)
            0: return -128;
            1: return 127;
            2: return -1;
            3: return 0;
            default: return int'($urandom_range(0, 255)) - 128;
        endcase
    endfunction

    task automatic test_random();
        int ops[NOPS];
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < NOPS; i++) ops[i] = pick_val();
            run_frame($sformatf("rand%0d", f), pick_val(), ops, int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            start = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sat_sub_accum_8bit.md
Name: sat_sub_accum_8bit

Overview:
Sequential signed 8-bit saturating subtract-accumulator. It is the inverse-direction companion to the team's combinational CLA adders with OVF/UVF detection. It takes a frame of N_OPS two's-complement operands over a valid/ready input stream and computes acc = sat(acc − x) for each operand. It returns the frame result over a valid/ready output stream, with sticky overflow/underflow flags. It sits between an operand source and a result consumer in the datapath test/compute chain.

Parameters:
N_OPS, 4, operands per frame; legal range 1..255.
ACC_W, 8, data width; fixed at 8, signed two's complement.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin frame; sampled only in IDLE
init_val  input  8  signed initial accumulator value, captured on an accepted start
in_valid  input  1  operand valid
in_ready  output  1  operand accepted when in_valid&in_ready
in_data  input  8  signed operand x
out_valid  output  1  frame result valid
out_ready  input  1  result consumed when out_valid&out_ready
out_data  output  8  signed frame result (accumulator)
ovf_sticky  output  1  set if any step saturated to +127 this frame
uvf_sticky  output  1  set if any step saturated to −128 this frame
busy  output  1  high when the FSM is not in IDLE
op_cnt  output  8  operands accepted so far this frame

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE
  - acc/out_data=0, op_cnt=0
  - ovf_sticky=0, uvf_sticky=0
  - in_ready=0, out_valid=0, busy=0
- Reset asserted mid-frame discards the frame; no partial result is emitted.
- All outputs are registered, or decoded from state only; no combinational input→output paths.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - start=1 → ACCUM next cycle; acc←init_val, op_cnt←0, both sticky flags←0.
- ACCUM:
  - in_ready=1, busy=1.
  - Each handshake cycle updates acc←sat(acc−in_data) and op_cnt←op_cnt+1.
  - When the beat accepted is number N_OPS (op_cnt==N_OPS−1 at the handshake), go to DONE next cycle.
  - in_valid=0 cycles are stalls: no state change.
  - start is ignored.
- DONE:
  - out_valid=1, in_ready=0; out_data=acc, held stable until handshake.
  - out_ready=1 → IDLE next cycle; out_valid drops.
  - Flags and out_data keep their values in IDLE until the next accepted start.
  - start asserted in DONE is ignored, even in the same cycle as out_ready.
- Latency:
  - out_valid rises the cycle after the last input handshake.
  - Minimum frame = 1 (start) + N_OPS + 1 (out) cycles.
  - A new start is accepted no earlier than the cycle after the output handshake.
- Arithmetic:
  - Diff formed at 9 bits: d = sext(acc) − sext(in_data).
  - Overflow: acc[7]=0, in_data[7]=1, d[7]=1 → acc←8'h7F, ovf_sticky←1.
  - Underflow: acc[7]=1, in_data[7]=0, d[7]=0 → acc←8'h80, uvf_sticky←1.
  - Otherwise acc←d[7:0].
  - Subtracting −128 from a non-negative acc always saturates to +127.
- op_cnt never exceeds N_OPS; it is not cleared on the output handshake.

Test Plan:
1. N_OPS=4, init 10, operands 3,4,−5,1 → acc 7,3,8,7; out_data=7 (0x07); ovf=uvf=0; out_valid one cycle after the 4th beat.
2. init 100, operands −50,−1,27,0 → acc 127(sat),127(sat),100,100; out_data=100; ovf_sticky=1, uvf_sticky=0.
3. init −100, operands 50,0,0,−1 → acc −128(sat),−128,−128,−127; out_data=0x81; uvf_sticky=1, ovf_sticky=0.
4. init 0, operands −128,0,0,0 with in_valid gaps of 2 cycles; out_ready low for 5 cycles:
   - out_data=0x7F with ovf_sticky=1, stable while stalled.
   - start pulses during ACCUM/DONE are ignored.
   - busy drops one cycle after the out_ready handshake.
5. Reset mid-frame: pull rst_n low asynchronously after 2 accepted beats → immediately all outputs 0, in_ready=0, busy=0. After release, a new frame (init 5, operands 1,1,1,1) yields out_data=1 with flags 0.
6. Back-to-back frames: start asserted the cycle after the output handshake is accepted. The second frame's sticky flags clear (first frame ovf=1, second frame clean result) → ovf_sticky=0.
